// File: rtl/arb_pkg.sv
// Shared definitions for the way arbiter: FSM encoding, width helper and
// default parameter values.
package arb_pkg;

    localparam int unsigned QOS_WIDTH_DEF    = 2;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(n)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/way_arbiter_if.sv
// Requester/slave handshake bundle between the upstream requesters and the
// way arbiter.
interface way_arbiter_if
    import arb_pkg::*;
#(
    parameter int unsigned REQ_NUM   = 3,
    parameter int unsigned QOS_WIDTH = QOS_WIDTH_DEF
);
    localparam int unsigned ID_W = clog2_min1(REQ_NUM);

    logic [REQ_NUM-1:0]           req;
    logic [REQ_NUM*QOS_WIDTH-1:0] req_qos;
    logic                         done;
    logic [REQ_NUM-1:0]           gnt;
    logic [ID_W-1:0]              gnt_id;
    logic                         busy;

    modport master (
        output req, req_qos, done,
        input  gnt, gnt_id, busy
    );

    modport slave (
        input  req, req_qos, done,
        output gnt, gnt_id, busy
    );

endinterface

// File: rtl/way_arbiter_rr_pick.sv
// Round-robin search: first set bit of cand starting after ptr, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned REQ_NUM = 3,
    localparam int unsigned ID_W   = clog2_min1(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] cand,
    input  logic [ID_W-1:0]    ptr,
    output logic [REQ_NUM-1:0] onehot_c,
    output logic [ID_W-1:0]    idx_c
);

    always_comb begin
        logic found;
        found    = 1'b0;
        onehot_c = '0;
        idx_c    = '0;
        for (int unsigned k = 1; k <= REQ_NUM; k++) begin
            int unsigned j;
            j = (int'(ptr) + k) % REQ_NUM;
            if (!found && cand[j]) begin
                found       = 1'b1;
                onehot_c[j] = 1'b1;
                idx_c       = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/way_arbiter.sv
// Grants one downstream slave port to one of REQ_NUM requesters, round-robin
// or QoS-priority, with an age-based anti-starvation override.
module way_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned REQ_NUM      = 3,
    parameter int unsigned QOS_WIDTH    = QOS_WIDTH_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned AGE_WIDTH    = 4
) (
    input  logic               pclk,
    input  logic               rst_b,
    input  logic [REQ_NUM-1:0] way_en,
    input  logic               qos_en,
    way_arbiter_if.slave       bus
);

    localparam int unsigned          ID_W    = clog2_min1(REQ_NUM);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(STARVE_LIMIT);
    localparam logic [ID_W-1:0]      PTR_RST = ID_W'(REQ_NUM - 1);

    arb_state_e           state;
    logic [ID_W-1:0]      ptr;
    logic [AGE_WIDTH-1:0] age [REQ_NUM];

    logic [REQ_NUM-1:0]   elig;
    logic [REQ_NUM-1:0]   starved;
    logic [REQ_NUM-1:0]   qos_max;
    logic [REQ_NUM-1:0]   cand;
    logic [REQ_NUM-1:0]   pick_oh;
    logic [ID_W-1:0]      pick_idx;
    logic [QOS_WIDTH-1:0] top_qos;

    assign elig = bus.req & way_en;

    // Candidate set: starved requesters first, then highest QoS or all eligible.
    always_comb begin
        starved = '0;
        qos_max = '0;
        top_qos = '0;
        cand    = elig;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (elig[i] && (age[i] == AGE_MAX)) begin
                starved[i] = 1'b1;
            end
            if (elig[i] && (bus.req_qos[i*QOS_WIDTH +: QOS_WIDTH] > top_qos)) begin
                top_qos = bus.req_qos[i*QOS_WIDTH +: QOS_WIDTH];
            end
        end
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (elig[i] && (bus.req_qos[i*QOS_WIDTH +: QOS_WIDTH] == top_qos)) begin
                qos_max[i] = 1'b1;
            end
        end
        if (|starved) begin
            cand = starved;
        end else if (qos_en) begin
            cand = qos_max;
        end
    end

    rr_pick #(
        .REQ_NUM (REQ_NUM)
    ) u_rr_pick (
        .cand     (cand),
        .ptr      (ptr),
        .onehot_c (pick_oh),
        .idx_c    (pick_idx)
    );

    // Grant FSM with registered outputs; ages move only on arbitration edges.
    always_ff @(posedge pclk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            ptr        <= PTR_RST;
            bus.gnt    <= '0;
            bus.gnt_id <= '0;
            bus.busy   <= 1'b0;
            for (int unsigned i = 0; i < REQ_NUM; i++) begin
                age[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (|elig) begin
                        bus.gnt    <= pick_oh;
                        bus.gnt_id <= pick_idx;
                        bus.busy   <= 1'b1;
                        ptr        <= pick_idx;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.done) begin
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            for (int unsigned i = 0; i < REQ_NUM; i++) begin
                if (!elig[i]) begin
                    age[i] <= '0;
                end else if (state == IDLE) begin
                    if (pick_oh[i]) begin
                        age[i] <= '0;
                    end else if (age[i] != AGE_MAX) begin
                        age[i] <= age[i] + AGE_WIDTH'(1);
                    end
                end
            end
        end
    end

    // A held grant is always a single requester matching gnt_id.
    assert property (@(posedge pclk) disable iff (!rst_b)
        bus.busy |-> ($onehot(bus.gnt) && bus.gnt[bus.gnt_id]));

    assert property (@(posedge pclk) disable iff (!rst_b)
        !bus.busy |-> (bus.gnt == '0));

endmodule

// File: tb/tb_way_arbiter.sv
// Scoreboard bench for way_arbiter: directed scenarios plus random traffic
// against a priority-score reference model.
module tb_way_arbiter;

    localparam int N   = 3;
    localparam int QW  = 2;
    localparam int LIM = 4;
    localparam int AW  = 4;

    logic         pclk  = 1'b0;
    logic         rst_b = 1'b0;
    logic [N-1:0] way_en;
    logic         qos_en;

    way_arbiter_if #(.REQ_NUM(N), .QOS_WIDTH(QW)) bus ();

    way_arbiter #(
        .REQ_NUM      (N),
        .QOS_WIDTH    (QW),
        .STARVE_LIMIT (LIM),
        .AGE_WIDTH    (AW)
    ) dut (
        .pclk   (pclk),
        .rst_b  (rst_b),
        .way_en (way_en),
        .qos_en (qos_en),
        .bus    (bus)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int m_last;
    int m_age [N];
    bit m_busy;
    int exp_q [$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_last = N - 1;
        m_busy = 1'b0;
        for (int k = 0; k < N; k++) m_age[k] = 0;
        exp_q.delete();
    endtask

    // Winner = highest score (starved beats any QoS), ties go to rr order.
    task automatic model_step(input bit d);
        logic [N-1:0] el;
        int best, bests, s, i;
        el = bus.req & way_en;
        if (!m_busy && el != '0) begin
            best  = -1;
            bests = -1;
            for (int k = 1; k <= N; k++) begin
                i = (m_last + k) % N;
                if (el[i]) begin
                    if (m_age[i] == LIM) s = 100;
                    else if (qos_en) s = int'(bus.req_qos[i*QW +: QW]);
                    else s = 0;
                    if (s > bests) begin
                        bests = s;
                        best  = i;
                    end
                end
            end
            exp_q.push_back(best);
            m_last = best;
            m_busy = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (el[k]) m_age[k] = (k == best) ? 0 : ((m_age[k] + 1 > LIM) ? LIM : m_age[k] + 1);
            end
        end else if (m_busy && d) begin
            m_busy = 1'b0;
        end
        for (int k = 0; k < N; k++) if (!el[k]) m_age[k] = 0;
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] we, input bit qe,
                         input logic [N*QW-1:0] qv, input bit d);
        @(negedge pclk);
        bus.req     = r;
        way_en      = we;
        qos_en      = qe;
        bus.req_qos = qv;
        bus.done    = d;
        model_step(d);
    endtask

    // Monitor: pops the expected winner when a grant starts, checks hold/idle otherwise.
    int cur_id    = -1;
    bit prev_busy = 1'b0;
    always @(posedge pclk) begin
        #1;
        if (!rst_b) begin
            prev_busy = 1'b0;
        end else begin
            chk("busy", longint'(bus.busy), longint'(m_busy));
            if (bus.busy && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_gnt: got %0b expected none at %0t", bus.gnt, $time);
                end else begin
                    cur_id = exp_q.pop_front();
                    chk("gnt", longint'(bus.gnt), longint'(1) << cur_id);
                    chk("gnt_id", longint'(bus.gnt_id), longint'(cur_id));
                end
            end else if (bus.busy && cur_id >= 0) begin
                chk("gnt_hold", longint'(bus.gnt), longint'(1) << cur_id);
            end else if (!bus.busy) begin
                chk("gnt_idle", longint'(bus.gnt), 0);
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        bus.req     = '0;
        bus.req_qos = '0;
        bus.done    = 1'b0;
        way_en      = '0;
        qos_en      = 1'b0;
        model_reset();

        #12;
        chk("reset_gnt", longint'(bus.gnt), 0);
        chk("reset_gnt_id", longint'(bus.gnt_id), 0);
        chk("reset_busy", longint'(bus.busy), 0);
        @(negedge pclk);
        rst_b = 1'b1;

        // Round-robin across all three, done the cycle after each grant
        for (int c = 0; c < 20; c++) cycle(3'b111, 3'b111, 1'b0, '0, m_busy);

        // r1 masked by way_en
        for (int c = 0; c < 20; c++) cycle(3'b111, 3'b101, 1'b0, '0, m_busy);

        // QoS r0=0 r1=3 r2=1: starvation override must interleave r2 and r0
        for (int c = 0; c < 30; c++) cycle(3'b111, 3'b111, 1'b1, 6'b01_11_00, m_busy);

        // Single requester: dropped req must not end the grant
        for (int c = 0; c < 4 && m_busy; c++) cycle(3'b000, 3'b111, 1'b0, '0, 1'b1);
        cycle(3'b100, 3'b111, 1'b0, '0, 1'b0);
        cycle(3'b100, 3'b111, 1'b0, '0, 1'b0);
        cycle(3'b000, 3'b111, 1'b0, '0, 1'b0);
        cycle(3'b000, 3'b111, 1'b0, '0, 1'b0);
        cycle(3'b000, 3'b111, 1'b0, '0, 1'b1);
        cycle(3'b000, 3'b111, 1'b0, '0, 1'b0);

        // way_en narrowed during a grant of r2
        cycle(3'b100, 3'b111, 1'b0, '0, 1'b0);
        for (int c = 0; c < 3; c++) cycle(3'b111, 3'b001, 1'b0, '0, 1'b0);
        for (int c = 0; c < 8; c++) cycle(3'b111, 3'b001, 1'b0, '0, m_busy);

        // Random traffic, including done pulses while idle
        for (int c = 0; c < 2000; c++) begin
            cycle(N'($urandom), N'($urandom), 1'($urandom), (N*QW)'($urandom),
                  m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of an r1 grant
        for (int c = 0; c < 4 && m_busy; c++) cycle(3'b000, 3'b111, 1'b0, '0, 1'b1);
        cycle(3'b010, 3'b111, 1'b0, '0, 1'b0);
        cycle(3'b010, 3'b111, 1'b0, '0, 1'b0);
        @(posedge pclk);
        #3;
        rst_b = 1'b0;
        #1;
        chk("async_rst_gnt", longint'(bus.gnt), 0);
        chk("async_rst_busy", longint'(bus.busy), 0);
        bus.req = '0;
        model_reset();
        @(negedge pclk);
        rst_b = 1'b1;
        for (int c = 0; c < 6; c++) cycle(3'b110, 3'b111, 1'b0, '0, m_busy);

        cycle(3'b000, 3'b111, 1'b0, '0, 1'b1);
        cycle(3'b000, 3'b111, 1'b0, '0, 1'b0);
        @(posedge pclk);
        #2;
        chk("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
